pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Sequencer on the board input clock that sits directly in front of the Gowin PLL wrapper. It drives the PLL `reset` pin, consumes the PLL `lock` output and decides when the generated clocks are usable. It releases the SoC reset only after lock has been continuously stable for a programmable time, retries the PLL on lock timeout, and reports a sticky failure after too many consecutive timeouts.

## Interface
- `RST_CYCLES`, 16: cycles `pll_reset` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles to wait for lock per attempt (1 ms at 50 MHz, ≥2).
- `LOCK_STABLE`, 1024: consecutive synchronized-lock-high cycles required before release (≥1).
- `MAX_RETRY`, 4: consecutive timeouts before `fail` (1..15).

Ports:
- `clk` in 1: free-running board clock, the same net that feeds PLL `clkin`.
- `resetn` in 1: asynchronous, active-low reset.
- `pll_lock` in 1: PLL `lock`, asynchronous to `clk`.
- `pll_reset` out 1: to PLL `reset`, active high.
- `sys_resetn` out 1: SoC reset request, active low. Consumers re-synchronize it into their own domains.
- `clk_ready` out 1: high while in RUN.
- `fail` out 1: sticky failure flag.
- `retry_cnt` out 4: count of consecutive lock timeouts, saturating at `MAX_RETRY`.

## Operation
- `pll_lock` passes through a 2-flop synchronizer (reset to 0) to form `lock_s`. All decisions use `lock_s`.
- A single counter `cnt` is shared by all states. Its width is `$clog2` of the largest parameter, plus 1. It clears on every state change.
- State RESET: `pll_reset`=1. After `RST_CYCLES` cycles, go to WAIT_LOCK.
- State WAIT_LOCK: `pll_reset`=0.
  - `lock_s`=1: go to STABLE.
  - `cnt` reaches `LOCK_TIMEOUT`-1 with `lock_s`=0: `retry_cnt`++. If the new value equals `MAX_RETRY`, go to FAIL; otherwise go to RESET.
  - If lock arrives in the same cycle as the timeout, lock wins.
- State STABLE: `cnt` counts consecutive `lock_s`=1 cycles.
  - `cnt` reaches `LOCK_STABLE`-1: go to RUN and clear `retry_cnt`.
  - `lock_s`=0: go back to WAIT_LOCK. This is a glitch, not a timeout: no PLL reset is issued and `retry_cnt` is unchanged.
- State RUN: `sys_resetn`=1, `clk_ready`=1. Lock loss (`lock_s`=0) is handled as described under Configuration.
- State FAIL: `pll_reset`=1, `fail`=1, `sys_resetn`=0. Only `resetn` exits this state.
- Outputs are registered from next-state, so they change on the same edge as the state register.
- Reset values (including when `resetn` is asserted in any state, mid-operation): state=RESET, `cnt`=0, `pll_reset`=1, `sys_resetn`=0, `clk_ready`=0, `fail`=0, `retry_cnt`=0, synchronizer=0.

## Timing
- Cycle numbering: edge 1 is the first rising `clk` edge with `resetn` high.
- With `pll_lock` held high throughout:
  - RESET covers edges 1..`RST_CYCLES`; `pll_reset` falls after edge `RST_CYCLES`.
  - STABLE is entered at edge `RST_CYCLES`+1.
  - `sys_resetn` and `clk_ready` rise after edge `RST_CYCLES`+1+`LOCK_STABLE`.
- Lock-assert to detection latency: 2 cycles (synchronizer).
- Lock-loss to `sys_resetn` low latency: 3 cycles (2 synchronizer + 1 state).
- Any `lock_s` low pulse of 1 cycle or longer is acted on; there is no filtering beyond the synchronizer.
- `sys_resetn` never glitches. It changes only on state transitions into or out of RUN.

## Configuration
- `PLL_SUP_AUTO_RECOVER_EN` defined: lock loss in RUN goes to RESET. `sys_resetn`=0 and `clk_ready`=0 on the same edge, then the full sequence reruns. `retry_cnt` starts from 0.
- `PLL_SUP_AUTO_RECOVER_EN` not defined: lock loss in RUN goes straight to FAIL, with `fail`=1 and the PLL held in reset until `resetn`.

## Test plan
Benches use `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE`=8, `MAX_RETRY`=2.
- Lock tied high → `pll_reset` high for edges 1..4; `sys_resetn` and `clk_ready` rise after edge 13; `retry_cnt`=0; `fail`=0.
- Lock never asserts → two 4-cycle `pll_reset` pulses; `retry_cnt` reads 1 then 2; FAIL entered after edge 48; `fail`=1 and `pll_reset`=1 held.
- Lock high, then a 1-cycle low pulse at STABLE `cnt`=5 → return to WAIT_LOCK with no `pll_reset` pulse; release 8 clean cycles after lock is stable again; `retry_cnt` unchanged.
- Lock dropped for 3 cycles while in RUN:
  - With `PLL_SUP_AUTO_RECOVER_EN`: `sys_resetn` falls 3 cycles later, `pll_reset` pulses 4 cycles, `sys_resetn` re-releases 13 cycles after the RESET re-entry edge.
  - Without the macro: `fail`=1 and `sys_resetn` stays 0.
- `resetn` asserted mid-STABLE and mid-FAIL → all outputs immediately at their reset values with no `clk` edge required; the sequence restarts from edge 1.
- One timeout followed by lock on the second attempt → `retry_cnt`=1 during the attempt, cleared to 0 on the edge RUN is entered.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: drives PLL reset, qualifies lock, releases SoC reset.
// Optional macro PLL_SUP_AUTO_RECOVER_EN: lock loss in RUN restarts the sequence instead of failing.
module pll_lock_supervisor #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_resetn,
    output logic       clk_ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] o_dbg_state
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B = (LOCK_STABLE > MAX_A) ? LOCK_STABLE : MAX_A;
    localparam int MAX_P = (MAX_RETRY > MAX_B) ? MAX_RETRY : MAX_B;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_lock_s;
    logic [3:0]       r_retry;
    logic [3:0]       w_retry_next;
    logic             w_cnt_run;
    logic             r_pll_reset;
    logic             r_sys_resetn;
    logic             r_clk_ready;
    logic             r_fail;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_lock;
            r_lock_s <= r_sync1;
        end
    end

    // Lock beats timeout in WAIT: the lock test is evaluated first.
    always_comb begin
        w_next       = r_state;
        w_retry_next = r_retry;
        w_cnt_run    = 1'b0;
        case (r_state)
            S_RESET: begin
                w_cnt_run = 1'b1;
                if (r_cnt == RST_LAST) w_next = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_run = 1'b1;
                if (r_lock_s) begin
                    w_next = S_STABLE;
                end else if (r_cnt == TO_LAST) begin
                    if (r_retry != RETRY_MAX) w_retry_next = r_retry + 4'd1;
                    w_next = ((r_retry + 4'd1) >= RETRY_MAX) ? S_FAIL : S_RESET;
                end
            end
            S_STABLE: begin
                w_cnt_run = 1'b1;
                if (!r_lock_s) begin
                    w_next = S_WAIT;
                end else if (r_cnt == STB_LAST) begin
                    w_next       = S_RUN;
                    w_retry_next = 4'd0;
                end
            end
            S_RUN: begin
                if (!r_lock_s) begin
`ifdef PLL_SUP_AUTO_RECOVER_EN
                    w_next       = S_RESET;
                    w_retry_next = 4'd0;
`else
                    w_next       = S_FAIL;
`endif
                end
            end
            S_FAIL: begin
                w_next = S_FAIL;
            end
            default: begin
                w_next = S_RESET;
            end
        endcase
    end

    // Outputs are registered from next-state so they move with the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_RESET;
            r_cnt        <= '0;
            r_retry      <= 4'd0;
            r_pll_reset  <= 1'b1;
            r_sys_resetn <= 1'b0;
            r_clk_ready  <= 1'b0;
            r_fail       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_cnt <= '0;
            else if (w_cnt_run)    r_cnt <= r_cnt + 1'b1;
            r_retry      <= w_retry_next;
            r_pll_reset  <= (w_next == S_RESET) || (w_next == S_FAIL);
            r_sys_resetn <= (w_next == S_RUN);
            r_clk_ready  <= (w_next == S_RUN);
            r_fail       <= (w_next == S_FAIL);
        end
    end

    assign pll_reset   = r_pll_reset;
    assign sys_resetn  = r_sys_resetn;
    assign clk_ready   = r_clk_ready;
    assign fail        = r_fail;
    assign retry_cnt   = r_retry;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters (4/20/8/2).
module tb_pll_lock_supervisor;

    logic       clk;
    logic       resetn;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_resetn;
    logic       clk_ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] dbg_state;

    int n_checks;
    int n_errors;
    int e;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STABLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    pll_lock_supervisor #(
        .RST_CYCLES  (4),
        .LOCK_TIMEOUT(20),
        .LOCK_STABLE (8),
        .MAX_RETRY   (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .sys_resetn (sys_resetn),
        .clk_ready  (clk_ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic run_to(input int n);
        while (e < n) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset), 1);
        check({tag, "_sys_resetn"}, 32'(sys_resetn), 0);
        check({tag, "_clk_ready"}, 32'(clk_ready), 0);
        check({tag, "_fail"}, 32'(fail), 0);
        check({tag, "_retry"}, 32'(retry_cnt), 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_RESET));
    endtask

    // Asserts resetn between edges (async path), then releases it so edge 1 is the next posedge.
    task automatic restart(input logic lock, input string tag);
        resetn   = 1'b0;
        pll_lock = lock;
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        e = 0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        e        = 0;
        resetn   = 1'b0;
        pll_lock = 1'b0;
        #12;

        // Lock tied high: release after edge 13
        restart(1'b1, "rst_a");
        run_to(3);
        check("a_pll_reset_e3", 32'(pll_reset), 1);
        run_to(4);
        check("a_pll_reset_e4", 32'(pll_reset), 0);
        run_to(5);
        check("a_state_e5", 32'(dbg_state), 32'(ST_STABLE));
        run_to(12);
        check("a_sys_resetn_e12", 32'(sys_resetn), 0);
        run_to(13);
        check("a_sys_resetn_e13", 32'(sys_resetn), 1);
        check("a_clk_ready_e13", 32'(clk_ready), 1);
        check("a_retry_e13", 32'(retry_cnt), 0);
        check("a_fail_e13", 32'(fail), 0);

        // Lock dropped 3 cycles while in RUN
        run_to(15);
        pll_lock = 1'b0;
        run_to(17);
        check("d_sys_resetn_e17", 32'(sys_resetn), 1);
        run_to(18);
        pll_lock = 1'b1;
        check("d_sys_resetn_e18", 32'(sys_resetn), 0);
        check("d_clk_ready_e18", 32'(clk_ready), 0);
`ifdef PLL_SUP_AUTO_RECOVER_EN
        check("d_pll_reset_e18", 32'(pll_reset), 1);
        run_to(21);
        check("d_pll_reset_e21", 32'(pll_reset), 1);
        run_to(22);
        check("d_pll_reset_e22", 32'(pll_reset), 0);
        run_to(30);
        check("d_sys_resetn_e30", 32'(sys_resetn), 0);
        run_to(31);
        check("d_sys_resetn_e31", 32'(sys_resetn), 1);
        check("d_retry_e31", 32'(retry_cnt), 0);
        check("d_fail_e31", 32'(fail), 0);
`else
        check("d_fail_e18", 32'(fail), 1);
        check("d_pll_reset_e18", 32'(pll_reset), 1);
        run_to(28);
        check("d_fail_e28", 32'(fail), 1);
        check("d_sys_resetn_e28", 32'(sys_resetn), 0);
        check("d_pll_reset_e28", 32'(pll_reset), 1);
`endif

        // Lock never asserts: two attempts, FAIL after edge 48
        restart(1'b0, "rst_b");
        run_to(23);
        check("b_retry_e23", 32'(retry_cnt), 0);
        check("b_pll_reset_e23", 32'(pll_reset), 0);
        run_to(24);
        check("b_retry_e24", 32'(retry_cnt), 1);
        check("b_pll_reset_e24", 32'(pll_reset), 1);
        run_to(27);
        check("b_pll_reset_e27", 32'(pll_reset), 1);
        run_to(28);
        check("b_pll_reset_e28", 32'(pll_reset), 0);
        run_to(47);
        check("b_retry_e47", 32'(retry_cnt), 1);
        check("b_fail_e47", 32'(fail), 0);
        run_to(48);
        check("b_retry_e48", 32'(retry_cnt), 2);
        check("b_fail_e48", 32'(fail), 1);
        check("b_pll_reset_e48", 32'(pll_reset), 1);
        run_to(58);
        check("b_fail_e58", 32'(fail), 1);
        check("b_pll_reset_e58", 32'(pll_reset), 1);
        check("b_state_e58", 32'(dbg_state), 32'(ST_FAIL));

        // resetn mid-FAIL, then a clean lock-high restart
        restart(1'b1, "rst_fail");
        run_to(13);
        check("f_sys_resetn_e13", 32'(sys_resetn), 1);

        // 1-cycle lock glitch at STABLE cnt=5: pll_lock low only at edge 9
        restart(1'b1, "rst_c");
        run_to(8);
        pll_lock = 1'b0;
        run_to(9);
        pll_lock = 1'b1;
        run_to(11);
        check("c_state_e11", 32'(dbg_state), 32'(ST_WAIT));
        check("c_pll_reset_e11", 32'(pll_reset), 0);
        run_to(12);
        check("c_state_e12", 32'(dbg_state), 32'(ST_STABLE));
        for (int k = 13; k <= 19; k++) begin
            run_to(k);
            check("c_pll_reset_hold", 32'(pll_reset), 0);
        end
        check("c_sys_resetn_e19", 32'(sys_resetn), 0);
        run_to(20);
        check("c_sys_resetn_e20", 32'(sys_resetn), 1);
        check("c_retry_e20", 32'(retry_cnt), 0);

        // resetn mid-STABLE
        restart(1'b1, "rst_e");
        run_to(8);
        check("e_state_e8", 32'(dbg_state), 32'(ST_STABLE));
        check("e_pll_reset_e8", 32'(pll_reset), 0);
        restart(1'b1, "rst_stable");
        run_to(12);
        check("e_sys_resetn_e12", 32'(sys_resetn), 0);
        run_to(13);
        check("e_sys_resetn_e13", 32'(sys_resetn), 1);

        // One timeout, lock on second attempt: retry 1 until RUN at edge 37
        restart(1'b0, "rst_g");
        run_to(26);
        pll_lock = 1'b1;
        check("g_retry_e26", 32'(retry_cnt), 1);
        run_to(29);
        check("g_state_e29", 32'(dbg_state), 32'(ST_STABLE));
        run_to(36);
        check("g_retry_e36", 32'(retry_cnt), 1);
        check("g_sys_resetn_e36", 32'(sys_resetn), 0);
        run_to(37);
        check("g_retry_e37", 32'(retry_cnt), 0);
        check("g_sys_resetn_e37", 32'(sys_resetn), 1);
        check("g_state_e37", 32'(dbg_state), 32'(ST_RUN));

        // Lock arrives in the same cycle as the timeout (lock_s high at edge 24)
        restart(1'b0, "rst_h");
        run_to(21);
        pll_lock = 1'b1;
        run_to(24);
        check("h_state_e24", 32'(dbg_state), 32'(ST_STABLE));
        check("h_retry_e24", 32'(retry_cnt), 0);
        check("h_pll_reset_e24", 32'(pll_reset), 0);
        run_to(32);
        check("h_sys_resetn_e32", 32'(sys_resetn), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
